// File: rtl/cv32e40s_data_obi_arbiter.sv
// Two-port arbiter for the data-side OBI request path with in-order response routing.
// Optional macro CV32E40S_ARB_RR_EN selects round-robin arbitration (default: port 0 priority).
module cv32e40s_data_obi_arbiter #(
    parameter int  MAX_OUTSTANDING = 2,
    parameter type obi_data_req_t  = logic [68:0]
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid_i,
    input  obi_data_req_t req_trans_i [2],
    output logic [1:0]    req_ready_o,
    output logic          valid_o,
    output obi_data_req_t trans_o,
    input  logic          ready_i,
    input  logic          resp_valid_i,
    output logic [1:0]    resp_valid_o,
    output logic          resp_unexp_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    arb_state_e       state_q;
    logic             gnt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             id_fifo_q [MAX_OUTSTANDING];
`ifdef CV32E40S_ARB_RR_EN
    logic             rr_ptr_q;
`endif

    logic gnt_sel, gnt, full, accept, pop, head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
`ifdef CV32E40S_ARB_RR_EN
        if (&req_valid_i) gnt_sel = rr_ptr_q;
        else              gnt_sel = req_valid_i[1] & ~req_valid_i[0];
`else
        gnt_sel = req_valid_i[1] & ~req_valid_i[0];
`endif
    end

    // Grant is pinned to port 0 in reset so trans_o shows the port-0 payload.
    assign gnt    = !rst_n ? 1'b0 : ((state_q == ARB_LOCK) ? gnt_q : gnt_sel);
    assign full   = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign valid_o = rst_n && !full && req_valid_i[gnt];
    assign accept  = valid_o && ready_i;
    assign trans_o = req_trans_i[gnt];

    assign head         = id_fifo_q[rd_ptr_q];
    assign pop          = rst_n && resp_valid_i && (cnt_q != '0);
    assign resp_unexp_o = rst_n && resp_valid_i && (cnt_q == '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_o[gi]  = rst_n && ready_i && !full && (gnt == 1'(gi));
            assign resp_valid_o[gi] = pop && (head == 1'(gi));
        end
    endgenerate

    assign cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (accept) id_fifo_q[wr_ptr_q] <= gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef CV32E40S_ARB_RR_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (accept) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)    rd_ptr_q <= next_ptr(rd_ptr_q);
`ifdef CV32E40S_ARB_RR_EN
            if (accept) rr_ptr_q <= ~gnt;
`endif
            case (state_q)
                ARB_IDLE: begin
                    if (valid_o && !ready_i) begin
                        state_q <= ARB_LOCK;
                        gnt_q   <= gnt;
                    end
                end
                ARB_LOCK: begin
                    if (accept) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40s_data_obi_arbiter.sv
// Randomized bench for cv32e40s_data_obi_arbiter: queue-based reference model plus a response scoreboard.
module tb_cv32e40s_data_obi_arbiter;
    localparam int MAXO = 2;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [68:0] req_trans [2];
    logic [1:0]  req_ready;
    logic        valid_o;
    logic [68:0] trans_o;
    logic        ready;
    logic        resp_valid;
    logic [1:0]  resp_valid_o;
    logic        resp_unexp;

    int checks = 0;
    int errors = 0;

    // Model state: IDs accepted but not yet answered, lock status, round-robin pointer.
    bit   m_out [$];
    bit   exp_q [$];
    bit   m_locked = 1'b0;
    bit   m_lg = 1'b0;
    bit   m_rr = 1'b0;
    logic [1:0] acc_seen = 2'b00;

    cv32e40s_data_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_trans_i  (req_trans),
        .req_ready_o  (req_ready),
        .valid_o      (valid_o),
        .trans_o      (trans_o),
        .ready_i      (ready),
        .resp_valid_i (resp_valid),
        .resp_valid_o (resp_valid_o),
        .resp_unexp_o (resp_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick(input logic [1:0] v);
`ifdef CV32E40S_ARB_RR_EN
        if (v == 2'b11) return m_rr;
`endif
        return (v == 2'b10);
    endfunction

    // Reference model: evaluates each cycle mid-period, when inputs are stable.
    always @(negedge clk) begin
        bit         g, full, ev;
        logic [1:0] er;
        if (!rst_n) begin
            chk("rst_valid", valid_o, 1'b0);
            chk("rst_ready", req_ready, 2'b00);
            chk("rst_resp", resp_valid_o, 2'b00);
            chk("rst_unexp", resp_unexp, 1'b0);
            chk("rst_trans", trans_o, req_trans[0]);
            m_out.delete();
            exp_q.delete();
            m_locked = 1'b0;
            m_rr     = 1'b0;
            acc_seen = 2'b00;
        end else begin
            full = (m_out.size() == MAXO);
            g    = m_locked ? m_lg : pick(req_valid);
            ev   = !full && req_valid[g];
            er   = (ready && !full) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("valid_o", valid_o, ev);
            chk("req_ready", req_ready, er);
            chk("trans_o", trans_o, req_trans[g]);
            chk("unexp", resp_unexp, resp_valid && (m_out.size() == 0));
            if (resp_valid && m_out.size() > 0) exp_q.push_back(m_out.pop_front());
            else chk("resp_idle", resp_valid_o, 2'b00);
            acc_seen = 2'b00;
            if (ev && ready) begin
                m_out.push_back(g);
                m_rr     = ~g;
                m_locked = 1'b0;
                acc_seen = g ? 2'b10 : 2'b01;
                $display("accept port %0d trans=%0h outstanding=%0d", g, req_trans[g], m_out.size());
            end else if (ev) begin
                m_locked = 1'b1;
                m_lg     = g;
            end
        end
    end

    // Scoreboard monitor: every routed response must match the oldest expected ID.
    always @(negedge clk) begin
        #1;
        if (resp_valid_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected_route", resp_valid_o, 2'b00);
            end else begin
                bit id;
                id = exp_q.pop_front();
                chk("resp_route", resp_valid_o, id ? 2'b10 : 2'b01);
                $display("response to port %0d", id);
            end
        end
    end

    initial begin
        int cyc, ph, rst_hold;
        rst_n      = 1'b0;
        ready      = 1'b0;
        resp_valid = 1'b0;
        req_valid  = 2'b00;
        rst_hold   = 0;
        for (int p = 0; p < 2; p++) req_trans[p] = {$urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            ph = cyc / (NCYC / 4);
            case (ph)
                0: begin ready = ($urandom_range(0, 3) != 0); resp_valid = ($urandom_range(0, 1) == 0); end
                1: begin ready = ($urandom_range(0, 3) == 0); resp_valid = ($urandom_range(0, 2) == 0); end
                2: begin ready = 1'b1;                        resp_valid = ($urandom_range(0, 4) == 0); end
                default: begin ready = $urandom_range(0, 1); resp_valid = ($urandom_range(0, 2) == 0); end
            endcase
            if (rst_hold > 0) rst_hold--;
            else if (ph == 3 && $urandom_range(0, 60) == 0) rst_hold = 2;
            rst_n = (rst_hold == 0);
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && acc_seen[p]) req_valid[p] = 1'b0;
                if (!req_valid[p]) begin
                    req_trans[p] = {$urandom, $urandom, $urandom};
                    req_valid[p] = (ph == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
                end
            end
        end
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        req_valid  = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
